// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32 pipeline sequencer: states, trap causes, MemOp fields.
// Used by pipeline_sequencer and mem_wait_timer.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_REGREAD = 3'd2,
        ST_ALU     = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_TRAP    = 3'd6,
        ST_UNUSED  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CAUSE_NONE        = 4'd0,
        CAUSE_FETCH_FAULT = 4'd1,
        CAUSE_LOAD_FAULT  = 4'd5,
        CAUSE_STORE_FAULT = 4'd7,
        CAUSE_DEC_EXC     = 4'd11,
        CAUSE_EXT_INT     = 4'd15
    } cause_e;

    localparam int MEMOP_ACCESS_BIT = 4;
    localparam int MEMOP_STORE_BIT  = 3;
    localparam int WAIT_W           = 8;

    // Moore stage controls decoded from the registered state.
    typedef struct packed {
        logic fetch_en;
        logic decode_en;
        logic reg_read_en;
        logic alu_en;
        logic mem_req;
        logic mem_we;
        logic reg_we;
        logic pc_update;
        logic trap_entry;
        logic trap_ret;
        logic int_ack;
    } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Bus wait-cycle counter: counts cycles a request waits for ready and flags a timeout
// once the count reaches MEM_WAIT_MAX with ready still low.
module mem_wait_timer
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (req && !ready) begin
            count <= count + WAIT_W'(1);
        end
    end

    // Ready in the limit cycle still completes the access.
    assign timeout = req && !ready && (count == WAIT_W'(MEM_WAIT_MAX));

endmodule

// File: rtl/pipeline_sequencer.sv
// Multi-cycle RV32 instruction sequencer driving the fetch/decode/regread/ALU/mem/WB enables.
// Optional SEQ_PERF_COUNTERS_EN adds the CycleCnt/InstRet counters (ports tied to 0 otherwise).
module pipeline_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 255,
    parameter int          CNT_W        = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             MemReady,
    input  logic             MultycyAlu,
    input  logic             AluDone,
    input  logic [4:0]       MemOp,
    input  logic             RegDwe,
    input  logic             DecInt,
    input  logic             TrapExit,
    input  logic             ExtInt,
    input  logic             IntEn,
    output logic             FetchEn,
    output logic             DecodeEn,
    output logic             RegReadEn,
    output logic             AluEn,
    output logic             MemReq,
    output logic             MemWe,
    output logic             RegWe,
    output logic             PcUpdate,
    output logic             TrapEntry,
    output logic             TrapRet,
    output logic             IntAck,
    output logic [3:0]       TrapCause,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstRet
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] cause_q;
    logic [3:0] trap_cause;
    ctrl_t      ctrl;
    logic       mem_phase;
    logic       timer_clear;
    logic       timeout;
    logic       unused_memop;

    assign unused_memop = ^MemOp[2:0];

    // Bus handshake: MemReq stays high in FETCH/MEM until MemReady is sampled high
    // on a rising Clk (transfer done) or the wait timer expires (request abandoned).
    assign mem_phase   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign timer_clear = (state_d != state_q);

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk    (Clk),
        .rst    (Reset),
        .clear  (timer_clear),
        .req    (mem_phase),
        .ready  (MemReady),
        .timeout(timeout)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            if (state_d == ST_TRAP && state_q != ST_TRAP) begin
                cause_q <= trap_cause;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        trap_cause = cause_q;
        ctrl       = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.fetch_en = 1'b1;
                ctrl.mem_req  = 1'b1;
                if (MemReady) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d    = ST_TRAP;
                    trap_cause = CAUSE_FETCH_FAULT;
                end
            end
            ST_DECODE: begin
                ctrl.decode_en = 1'b1;
                state_d        = ST_REGREAD;
            end
            ST_REGREAD: begin
                ctrl.reg_read_en = 1'b1;
                if (DecInt) begin
                    state_d    = ST_TRAP;
                    trap_cause = CAUSE_DEC_EXC;
                end else begin
                    state_d = ST_ALU;
                end
            end
            ST_ALU: begin
                ctrl.alu_en = 1'b1;
                if (!MultycyAlu || AluDone) begin
                    state_d = MemOp[MEMOP_ACCESS_BIT] ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = MemOp[MEMOP_STORE_BIT];
                if (MemReady) begin
                    state_d = ST_WB;
                end else if (timeout) begin
                    state_d    = ST_TRAP;
                    trap_cause = MemOp[MEMOP_STORE_BIT] ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                end
            end
            ST_WB: begin
                ctrl.reg_we    = RegDwe;
                ctrl.pc_update = 1'b1;
                ctrl.trap_ret  = TrapExit;
                // Interrupts are only taken at an instruction boundary, after retirement.
                if (ExtInt && IntEn) begin
                    state_d    = ST_TRAP;
                    trap_cause = CAUSE_EXT_INT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_TRAP: begin
                ctrl.trap_entry = 1'b1;
                ctrl.int_ack    = 1'b1;
                ctrl.pc_update  = 1'b1;
                state_d         = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Reset masks every control straight away so an in-flight bus access is dropped.
    assign FetchEn   = ctrl.fetch_en    & ~Reset;
    assign DecodeEn  = ctrl.decode_en   & ~Reset;
    assign RegReadEn = ctrl.reg_read_en & ~Reset;
    assign AluEn     = ctrl.alu_en      & ~Reset;
    assign MemReq    = ctrl.mem_req     & ~Reset;
    assign MemWe     = ctrl.mem_we      & ~Reset;
    assign RegWe     = ctrl.reg_we      & ~Reset;
    assign PcUpdate  = ctrl.pc_update   & ~Reset;
    assign TrapEntry = ctrl.trap_entry  & ~Reset;
    assign TrapRet   = ctrl.trap_ret    & ~Reset;
    assign IntAck    = ctrl.int_ack     & ~Reset;
    assign TrapCause = cause_q;
    assign State     = state_q;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] ret_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cycle_q <= '0;
            ret_q   <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (state_q == ST_WB) begin
                ret_q <= ret_q + CNT_W'(1);
            end
        end
    end

    assign CycleCnt = cycle_q;
    assign InstRet  = ret_q;
`else
    assign CycleCnt = '0;
    assign InstRet  = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: instruction-level model expands each
// randomized instruction into its expected per-cycle outputs.
module tb_pipeline_sequencer;

    localparam int MAX   = 4;
    localparam int CNT_W = 32;
`ifdef SEQ_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             Clk, Reset, MemReady, MultycyAlu, AluDone, RegDwe, DecInt, TrapExit, ExtInt, IntEn;
    logic [4:0]       MemOp;
    logic             FetchEn, DecodeEn, RegReadEn, AluEn, MemReq, MemWe, RegWe, PcUpdate;
    logic             TrapEntry, TrapRet, IntAck;
    logic [3:0]       TrapCause;
    logic [2:0]       State;
    logic [CNT_W-1:0] CycleCnt, InstRet;

    pipeline_sequencer #(.MEM_WAIT_MAX(MAX), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .MemReady(MemReady), .MultycyAlu(MultycyAlu), .AluDone(AluDone),
        .MemOp(MemOp), .RegDwe(RegDwe), .DecInt(DecInt), .TrapExit(TrapExit), .ExtInt(ExtInt),
        .IntEn(IntEn), .FetchEn(FetchEn), .DecodeEn(DecodeEn), .RegReadEn(RegReadEn), .AluEn(AluEn),
        .MemReq(MemReq), .MemWe(MemWe), .RegWe(RegWe), .PcUpdate(PcUpdate), .TrapEntry(TrapEntry),
        .TrapRet(TrapRet), .IntAck(IntAck), .TrapCause(TrapCause), .State(State),
        .CycleCnt(CycleCnt), .InstRet(InstRet)
    );

    // ---------------- clock ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct packed {
        logic fe, de, re, ae, mr, mw, rw, pc, te, tr, ia;
        logic [2:0] st;
        logic [3:0] cause;
        logic [CNT_W-1:0] cyc, ret;
    } exp_t;

    exp_t             exp_q[$];
    int               tests = 0;
    int               fails = 0;
    logic [3:0]       cause_m;
    logic [CNT_W-1:0] cyc_m, ret_m;
    logic             ext_hold;
    logic [2:0]       st_tr[$];
    int               n_regwe, n_aluen, n_memwait, n_memwe, n_mem, n_te, n_ia;

    // ---------------- scoreboard / compare ----------------
    always @(negedge Clk) begin
        exp_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{fe: FetchEn, de: DecodeEn, re: RegReadEn, ae: AluEn, mr: MemReq, mw: MemWe,
                  rw: RegWe, pc: PcUpdate, te: TrapEntry, tr: TrapRet, ia: IntAck, st: State,
                  cause: TrapCause, cyc: CycleCnt, ret: InstRet};
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, g, e);
            end
            st_tr.push_back(State);
            if (RegWe) n_regwe++;
            if (AluEn) n_aluen++;
            if (State == 3'd4) n_mem++;
            if (State == 3'd4 && MemReq && !MemReady) n_memwait++;
            if (MemWe) n_memwe++;
            if (TrapEntry) n_te++;
            if (IntAck) n_ia++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clear_obs();
        st_tr.delete();
        n_regwe = 0; n_aluen = 0; n_memwait = 0; n_memwe = 0; n_mem = 0; n_te = 0; n_ia = 0;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    // ---------------- driver ----------------
    // One clock slot: drive inputs just after the edge, queue this cycle's expected outputs.
    task automatic slot(input logic rst, input logic rdy, input logic done, input logic dint,
                        input logic eint, input exp_t e_in);
        exp_t e;
        e        = e_in;
        Reset    = rst;
        MemReady = rdy;
        AluDone  = done;
        DecInt   = dint;
        ExtInt   = ext_hold ? 1'b1 : eint;
        if (rst) begin
            cause_m = '0;
            ret_m   = '0;
            cyc_m   = '0;
            e       = '0;
        end else begin
            e.cause = cause_m;
            e.cyc   = PERF ? cyc_m : '0;
            e.ret   = PERF ? ret_m : '0;
        end
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        if (!rst) cyc_m = cyc_m + 1;
    endtask

    task automatic take_trap(input logic [3:0] c);
        exp_t e;
        cause_m = c;
        e = blank(3'd6);
        e.te = 1'b1; e.ia = 1'b1; e.pc = 1'b1;
        slot(1'b0, rb(), rb(), rb(), rb(), e);
    endtask

    // Expands one instruction into cycles following the stage rules.
    task automatic run_instr(input int fetch_d, input int alu_n, input logic mc, input logic [4:0] mop,
                             input int mem_d, input logic dwe, input logic texit, input logic dint,
                             input logic eint, input logic ie, input int abort_at);
        exp_t e;
        int   n;
        logic rdy;
        MultycyAlu = mc; MemOp = mop; RegDwe = dwe; TrapExit = texit; IntEn = ie;
        for (int i = 0; ; i++) begin
            rdy = (i == fetch_d);
            e = blank(3'd0); e.fe = 1'b1; e.mr = 1'b1;
            slot(1'b0, rdy, rb(), rb(), rb(), e);
            if (rdy) break;
            if (i == MAX) begin take_trap(4'd1); return; end
        end
        e = blank(3'd1); e.de = 1'b1;
        slot(1'b0, rb(), rb(), rb(), rb(), e);
        e = blank(3'd2); e.re = 1'b1;
        slot(1'b0, rb(), rb(), dint, rb(), e);
        if (dint) begin take_trap(4'd11); return; end
        n = mc ? alu_n : 1;
        for (int i = 0; i < n; i++) begin
            e = blank(3'd3); e.ae = 1'b1;
            slot(1'b0, rb(), mc ? (i == n - 1) : rb(), rb(), rb(), e);
        end
        if (mop[4]) begin
            for (int i = 0; ; i++) begin
                if (i == abort_at) begin
                    slot(1'b1, 1'b0, rb(), rb(), rb(), blank(3'd0));
                    return;
                end
                rdy = (i == mem_d);
                e = blank(3'd4); e.mr = 1'b1; e.mw = mop[3];
                slot(1'b0, rdy, rb(), rb(), rb(), e);
                if (rdy) break;
                if (i == MAX) begin take_trap(mop[3] ? 4'd7 : 4'd5); return; end
            end
        end
        e = blank(3'd5); e.rw = dwe; e.pc = 1'b1; e.tr = texit;
        slot(1'b0, rb(), rb(), rb(), eint, e);
        ret_m = ret_m + 1;
        if ((eint || ext_hold) && ie) take_trap(4'd15);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] add_seq [5];
        logic [4:0] mop;
        int         fd, md, ab;
        add_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
        Reset = 1'b0; MemReady = 1'b0; MultycyAlu = 1'b0; AluDone = 1'b0; MemOp = '0;
        RegDwe = 1'b0; DecInt = 1'b0; TrapExit = 1'b0; ExtInt = 1'b0; IntEn = 1'b0;
        ext_hold = 1'b0; cause_m = '0; cyc_m = '0; ret_m = '0;
        clear_obs();
        @(posedge Clk);
        #1;
        repeat (3) slot(1'b1, rb(), rb(), rb(), rb(), blank(3'd0));

        // ADD-type: 0,1,2,3,5 then back to FETCH
        clear_obs();
        run_instr(0, 1, 1'b0, 5'b00000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        chk("add_len", st_tr.size(), 5);
        for (int i = 0; i < 5 && i < st_tr.size(); i++) chk("add_state_seq", st_tr[i], add_seq[i]);
        chk("add_regwe_count", n_regwe, 1);
        chk("add_state_after", State, 0);
        chk("add_instret", InstRet, PERF ? 1 : 0);
        chk("add_model_ret", ret_m, 1);

        // Load with 3 wait cycles in MEM
        clear_obs();
        run_instr(0, 1, 1'b0, 5'b10010, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        chk("load_wait_cycles", n_memwait, 3);
        chk("load_mem_cycles", n_mem, 4);
        chk("load_memwe", n_memwe, 0);
        chk("load_regwe", n_regwe, 1);

        // Divide: 8-cycle ALU, no MEM
        clear_obs();
        run_instr(0, 8, 1'b1, 5'b00000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        chk("div_aluen_cycles", n_aluen, 8);
        chk("div_mem_cycles", n_mem, 0);

        // Store timeout
        clear_obs();
        run_instr(0, 1, 1'b0, 5'b11000, 99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        chk("store_fault_cause", TrapCause, 7);
        chk("store_fault_model_cause", cause_m, 7);
        chk("store_trapentry_pulses", n_te, 1);
        chk("store_intack_pulses", n_ia, 1);
        chk("store_fault_regwe", n_regwe, 0);

        // DecInt beats ExtInt, then ExtInt taken after the next instruction retires
        ext_hold = 1'b1;
        run_instr(0, 1, 1'b0, 5'b00000, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        chk("decint_priority_cause", TrapCause, 11);
        clear_obs();
        run_instr(0, 1, 1'b0, 5'b00000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        ext_hold = 1'b0;
        chk("extint_cause", TrapCause, 15);
        chk("extint_wb_then_trap", (st_tr.size() >= 2) ? {st_tr[st_tr.size()-2], st_tr[st_tr.size()-1]} : 6'd0, {3'd5, 3'd6});

        // Reset in the middle of MEM
        run_instr(0, 1, 1'b0, 5'b10010, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        chk("reset_memreq", MemReq, 0);
        chk("reset_regwe", RegWe, 0);
        Reset = 1'b0;
        #1;
        chk("release_state", State, 0);
        chk("release_cyclecnt", CycleCnt, 0);
        chk("release_instret", InstRet, 0);
        chk("release_fetchen", FetchEn, 1);

        // Randomized instruction stream
        for (int k = 0; k < 150; k++) begin
            fd  = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, MAX + 2);
            md  = ($urandom_range(0, 9) < 5) ? 0 : $urandom_range(1, MAX + 2);
            ab  = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1;
            mop = 5'($urandom_range(0, 31));
            run_instr(fd, $urandom_range(1, 5), rb(), mop, md, rb(), rb(),
                      $urandom_range(0, 7) == 0, rb(), rb(), ab);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
